// File: rtl/button_conditioner.sv
// Button front-end: 2-flop sync, debounce and press/release/move strobes per channel.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat strobes on move_pulse.
module button_conditioner #(
   parameter int N_BTN           = 4,
   parameter int CNT_W           = 20,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RPT_W           = 24,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_n,
   input  logic             enable,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] move_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (64'd1 << CNT_W) ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_W < 1) begin : g_param_check
      $error("button_conditioner: illegal parameter value");
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;
`endif

   logic [N_BTN-1:0] r_sync_p0;
   logic [N_BTN-1:0] r_sync_p1;
   logic [N_BTN-1:0] w_s;

   // Stage p0/p1: synchroniser kept in raw active-low polarity, so reset means released
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync_p0 <= '1;
         r_sync_p1 <= '1;
      end else begin
         r_sync_p0 <= btn_n;
         r_sync_p1 <= r_sync_p0;
      end
   end

   assign w_s = ~r_sync_p1;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_lvl;
      logic             r_prs;
      logic             r_rel;
      logic             r_mov;
      logic             w_accept;
      logic             w_rise;
      logic             w_fall;
      logic             w_rpt;

      assign w_accept = (w_s[g] != r_lvl) && (r_cnt == DB_LAST);
      assign w_rise   = w_accept & w_s[g];
      assign w_fall   = w_accept & ~w_s[g];

      // Stage p2: debounce counter, level and registered strobes
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
            r_prs <= 1'b0;
            r_rel <= 1'b0;
            r_mov <= 1'b0;
         end else begin
            if (w_s[g] == r_lvl) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_lvl <= w_s[g];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            r_prs <= w_rise & enable;
            r_rel <= w_fall & enable;
            r_mov <= (w_rise & enable) | w_rpt;
         end
      end

`ifdef BTN_AUTOREPEAT_EN
      rpt_state_t       r_state;
      rpt_state_t       w_state_nxt;
      logic [RPT_W-1:0] r_rcnt;
      logic [RPT_W-1:0] w_rcnt_nxt;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
         end
      end

      // A release accepted on the same edge as a due repeat suppresses the repeat
      always_comb begin
         w_state_nxt = r_state;
         w_rcnt_nxt  = r_rcnt;
         w_rpt       = 1'b0;
         if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_rise) begin
                     w_state_nxt = ST_DELAY;
                     w_rcnt_nxt  = '0;
                  end
               end
               ST_DELAY: begin
                  if (!r_lvl || w_fall) begin
                     w_state_nxt = ST_IDLE;
                     w_rcnt_nxt  = '0;
                  end else if (r_rcnt == RD_LAST) begin
                     w_rpt       = 1'b1;
                     w_state_nxt = ST_REPEAT;
                     w_rcnt_nxt  = '0;
                  end else begin
                     w_rcnt_nxt  = r_rcnt + RPT_W'(1);
                  end
               end
               ST_REPEAT: begin
                  if (!r_lvl || w_fall) begin
                     w_state_nxt = ST_IDLE;
                     w_rcnt_nxt  = '0;
                  end else if (r_rcnt == RP_LAST) begin
                     w_rpt       = 1'b1;
                     w_rcnt_nxt  = '0;
                  end else begin
                     w_rcnt_nxt  = r_rcnt + RPT_W'(1);
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_rcnt_nxt  = '0;
               end
            endcase
         end
      end
`else
      assign w_rpt = 1'b0;
`endif

      assign level[g]         = r_lvl;
      assign press_pulse[g]   = r_prs;
      assign release_pulse[g] = r_rel;
      assign move_pulse[g]    = r_mov;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5).
// Expectations track BTN_AUTOREPEAT_EN the same way the design build does.
module tb_button_conditioner;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_n = 4'hF;
   logic       enable = 1'b1;
   logic [3:0] level;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] move_pulse;

   int n_checks = 0;
   int n_errors = 0;

   button_conditioner #(
      .N_BTN(4), .CNT_W(20), .DEBOUNCE_CYCLES(DB), .RPT_W(24),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .btn_n(btn_n), .enable(enable),
      .level(level), .press_pulse(press_pulse),
      .release_pulse(release_pulse), .move_pulse(move_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: s is ~btn_n seen two edges late; a level flips once the last
   // DB samples of s all disagree with it. Repeats fire at RD, RD+RP, ... edges after the press.
   localparam logic [31:0] MASK = (32'd1 << DB) - 32'd1;
   logic [3:0]  m_pipe0, m_pipe1;
   logic [3:0]  m_level, m_press, m_rel, m_move;
   logic [31:0] m_hist [4];
   int          m_held [4];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pipe0 = 4'hF;
         m_pipe1 = 4'hF;
         m_level = 4'h0;
         m_press = 4'h0;
         m_rel   = 4'h0;
         m_move  = 4'h0;
         for (int i = 0; i < 4; i++) begin
            m_hist[i] = 32'd0;
            m_held[i] = -1;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic s, acc, rpt;
            s = ~m_pipe1[i];
            m_hist[i] = {m_hist[i][30:0], s};
            acc = ((m_hist[i] & MASK) == (m_level[i] ? 32'd0 : MASK));
            rpt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            if (!enable || (acc && m_level[i])) begin
               m_held[i] = -1;
            end else if (m_held[i] >= 0) begin
               m_held[i]++;
               if (m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) rpt = 1'b1;
            end
            if (acc && !m_level[i] && enable) m_held[i] = 0;
`endif
            m_press[i] = acc & ~m_level[i] & enable;
            m_rel[i]   = acc & m_level[i] & enable;
            m_move[i]  = m_press[i] | rpt;
            if (acc) m_level[i] = ~m_level[i];
         end
         m_pipe1 = m_pipe0;
         m_pipe0 = btn_n;
      end
   end

   always @(negedge clk) begin
      check("model_level", level, m_level);
      check("model_press", press_pulse, m_press);
      check("model_release", release_pulse, m_rel);
      check("model_move", move_pulse, m_move);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] mask, pmask, exp_mask;
      logic        acc;

      // Reset held with all buttons pressed
      reset = 1'b0; btn_n = 4'h0; enable = 1'b1;
      step(3);
      check("rst_level", level, 4'h0);
      check("rst_strobes", press_pulse | release_pulse | move_pulse, 4'h0);
      reset = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step(1);
         check("rst_level_early", level, 4'h0);
         check("rst_strobes_early", press_pulse | release_pulse | move_pulse, 4'h0);
      end
      step(1);
      check("rst_level_c6", level, 4'hF);
      check("rst_press_c6", press_pulse, 4'hF);
      check("rst_move_c6", move_pulse, 4'hF);
      step(1);
      check("rst_press_c7", press_pulse, 4'h0);

      // Bounce rejection on bit 0
      reset = 1'b0; btn_n = 4'hF;
      step(2);
      reset = 1'b1;
      step(8);
      btn_n[0] = 1'b0; step(2);
      btn_n[0] = 1'b1; step(2);
      btn_n[0] = 1'b0; step(2);
      btn_n[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step(1);
         check("bounce_level0", level[0], 1'b0);
         check("bounce_press0", press_pulse[0] | move_pulse[0], 1'b0);
      end
      btn_n[0] = 1'b0;
      step(5);
      check("bounce_level0_c5", level[0], 1'b0);
      step(1);
      check("bounce_level0_c6", level[0], 1'b1);
      check("bounce_press0_c6", press_pulse[0], 1'b1);

      // Press then release of bit 2
      btn_n[2] = 1'b0;
      step(6);
      check("rel_level2_on", level[2], 1'b1);
      check("rel_press2", press_pulse[2], 1'b1);
      step(3);
      btn_n[2] = 1'b1;
      step(5);
      check("rel_level2_c5", level[2], 1'b1);
      check("rel_release2_c5", release_pulse[2], 1'b0);
      step(1);
      check("rel_level2_c6", level[2], 1'b0);
      check("rel_release2_c6", release_pulse[2], 1'b1);
      check("rel_move2_c6", move_pulse[2], 1'b0);
      step(1);
      check("rel_release2_c7", release_pulse[2], 1'b0);

      // Hold-to-repeat on bit 1
      btn_n = 4'hF;
      step(10);
      btn_n[1] = 1'b0;
      step(6);
      check("rpt_press1", press_pulse[1], 1'b1);
      mask = 64'd0;
      for (int off = 0; off < 60; off++) begin
         if (move_pulse[1]) mask |= (64'd1 << off);
         if (off == 33) btn_n[1] = 1'b1;
         step(1);
      end
`ifdef BTN_AUTOREPEAT_EN
      exp_mask = 64'h0000_0008_4210_8401;
`else
      exp_mask = 64'h1;
`endif
      check("rpt_move1_positions", mask, exp_mask);

      // Enable mask on bit 3
      btn_n = 4'hF;
      step(10);
      enable = 1'b0;
      btn_n[3] = 1'b0;
      step(6);
      check("en_level3", level[3], 1'b1);
      check("en_press3_masked", press_pulse[3], 1'b0);
      check("en_move3_masked", move_pulse[3], 1'b0);
      enable = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step(1);
         acc |= press_pulse[3] | move_pulse[3];
      end
      check("en_held_no_strobe", acc, 1'b0);
      btn_n[3] = 1'b1;
      step(8);
      btn_n[3] = 1'b0;
      step(6);
      check("en_repress_press3", press_pulse[3], 1'b1);
      check("en_repress_move3", move_pulse[3], 1'b1);

      // Async reset during repeat with bit 1 held
      btn_n = 4'hF;
      step(10);
      btn_n[1] = 1'b0;
      step(6);
      step(12);
      #1 reset = 1'b0;
      #1;
      check("arst_level", level, 4'h0);
      check("arst_strobes", press_pulse | release_pulse | move_pulse, 4'h0);
      step(3);
      reset = 1'b1;
      mask = 64'd0;
      pmask = 64'd0;
      for (int off = 1; off <= 20; off++) begin
         step(1);
         if (press_pulse[1]) pmask |= (64'd1 << off);
         if (move_pulse[1]) mask |= (64'd1 << off);
      end
      check("arst_press1_positions", pmask, 64'h40);
`ifdef BTN_AUTOREPEAT_EN
      exp_mask = 64'h10040;
`else
      exp_mask = 64'h40;
`endif
      check("arst_move1_positions", mask, exp_mask);

      // Randomised traffic, checked every cycle against the model
      for (int c = 0; c < 4000; c++) begin
         int rate;
         rate = (c < 2000) ? 11 : 29;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, rate) == 0) btn_n[i] = ~btn_n[i];
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         if (c == 2000) begin
            reset = 1'b0;
            step(2);
            reset = 1'b1;
         end
         step(1);
      end
      enable = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
